// File: rtl/uart_tx_arb_pkg.sv
// Shared state type and watchdog constants for the UART TX arbiter.
package uart_tx_arb_pkg;

  typedef enum logic [1:0] {
    IDLE_S = 2'd0,
    LOAD_S = 2'd1,
    BUSY_S = 2'd2
  } tx_arb_state;

  localparam int TIMEOUT_W = 16;
  localparam logic [TIMEOUT_W-1:0] TIMEOUT_CYC_DEF = 16'd50000;

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin picker: first asserted request at or above rr_ptr,
// wrapping modulo NUM_REQ.
module uart_rr_picker
  import uart_tx_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IDX_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic               any_req,
  output logic [IDX_W-1:0]   win
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] idx;

  // Scan offsets from farthest to nearest so the closest hit is written last.
  always_comb begin
    any_req = |req;
    win     = rr_ptr;
    sum     = '0;
    idx     = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      sum = {1'b0, rr_ptr} + (IDX_W + 1)'(off);
      if (sum >= (IDX_W + 1)'(NUM_REQ)) begin
        sum = sum - (IDX_W + 1)'(NUM_REQ);
      end
      idx = sum[IDX_W-1:0];
      if (req[idx]) begin
        win = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX shifter among NUM_REQ requesters.
// Define UART_TX_ARB_LOCK_EN to add req_lock for back-to-back locked bursts.
module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W = 8,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  localparam int IDX_W = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      arb_en,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
`ifdef UART_TX_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]        req_lock,
`endif
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      tx_start,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_done,
  output logic [IDX_W-1:0]          owner,
  output logic                      busy,
  output logic                      timeout_err
);

  tx_arb_state state, next_state;

  logic [IDX_W-1:0]     rr_ptr;
  logic [IDX_W-1:0]     win;
  logic [IDX_W-1:0]     owner_inc;
  logic                 any_req;
  logic [TIMEOUT_W-1:0] wdog;
  logic [DATA_W-1:0]    req_bytes [NUM_REQ];
  logic                 take_grant;
  logic                 relock;
  logic                 release_bus;
  logic                 fire_timeout;
  logic                 hold_lock;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_bytes
    assign req_bytes[i] = req_data[i*DATA_W +: DATA_W];
  end

  uart_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req     (req),
    .rr_ptr  (rr_ptr),
    .any_req (any_req),
    .win     (win)
  );

  assign owner_inc = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + IDX_W'(1);

`ifdef UART_TX_ARB_LOCK_EN
  assign hold_lock = req_lock[owner] & req[owner] & arb_en;
`else
  assign hold_lock = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE_S;
    end else begin
      state <= next_state;
    end
  end

  // Outputs are decoded from state and owner only, never from inputs.
  always_comb begin
    next_state   = state;
    take_grant   = 1'b0;
    relock       = 1'b0;
    release_bus  = 1'b0;
    fire_timeout = 1'b0;
    tx_start     = 1'b0;
    gnt          = '0;
    busy         = (state != IDLE_S);
    case (state)
      IDLE_S: begin
        if (arb_en && any_req) begin
          take_grant = 1'b1;
          next_state = LOAD_S;
        end
      end
      LOAD_S: begin
        tx_start   = 1'b1;
        gnt[owner] = 1'b1;
        next_state = BUSY_S;
      end
      BUSY_S: begin
        // Completion beats a watchdog expiry landing on the same cycle.
        if (tx_done) begin
          if (hold_lock) begin
            relock     = 1'b1;
            next_state = LOAD_S;
          end else begin
            release_bus = 1'b1;
            next_state  = IDLE_S;
          end
        end else if (wdog == TIMEOUT_CYC - TIMEOUT_W'(1)) begin
          fire_timeout = 1'b1;
          release_bus  = 1'b1;
          next_state   = IDLE_S;
        end
      end
      default: next_state = IDLE_S;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr      <= '0;
      owner       <= '0;
      wdog        <= '0;
      tx_data     <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= fire_timeout;
      if (take_grant) begin
        owner   <= win;
        tx_data <= req_bytes[win];
      end
      if (relock) begin
        tx_data <= req_bytes[owner];
      end
      if (release_bus) begin
        rr_ptr <= owner_inc;
      end
      if (state == LOAD_S) begin
        wdog <= '0;
      end else if (state == BUSY_S) begin
        wdog <= wdog + TIMEOUT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized
// frames checked against a transaction-level round-robin model.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int TO = 20;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          arb_en;
  logic [N-1:0]  req;
  logic [N*DW-1:0] req_data;
  logic          tx_done;
  logic [N-1:0]  gnt;
  logic          tx_start;
  logic [DW-1:0] tx_data;
  logic [1:0]    owner;
  logic          busy;
  logic          timeout_err;
`ifdef UART_TX_ARB_LOCK_EN
  logic [N-1:0]  req_lock;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [N-1:0]  pend;
  logic [DW-1:0] req_byte [N];
  int            rr;

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(DW), .TIMEOUT_CYC(16'(TO))) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .arb_en      (arb_en),
    .req         (req),
    .req_data    (req_data),
`ifdef UART_TX_ARB_LOCK_EN
    .req_lock    (req_lock),
`endif
    .gnt         (gnt),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_done     (tx_done),
    .owner       (owner),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus();
    req = pend;
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = req_byte[i];
  endtask

  // Reference arbitration: first pending requester at or after rr, wrapping.
  function automatic int pick();
    for (int off = 0; off < N; off++) begin
      if (pend[(rr + off) % N]) return (rr + off) % N;
    end
    return -1;
  endfunction

  task automatic do_reset();
    rst_n   = 1'b0;
    arb_en  = 1'b1;
    tx_done = 1'b0;
    pend    = '0;
    apply_stimulus();
    step();
    step();
    check_output("rst_busy", busy, 0);
    check_output("rst_tx_start", tx_start, 0);
    check_output("rst_gnt", gnt, 0);
    check_output("rst_timeout_err", timeout_err, 0);
    check_output("rst_owner", owner, 0);
    check_output("rst_tx_data", tx_data, 0);
    rst_n = 1'b1;
    rr = 0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      check_output("idle_busy", busy, 0);
      check_output("idle_pulses", {tx_start, gnt, timeout_err}, 0);
    end
  endtask

  // One arbitration: present pend, expect the grant one cycle later, then
  // return tx_done on BUSY cycle done_k (0 means never, so the watchdog fires).
  // The winner re-requests renew more times; a held lock chains those frames.
  task automatic run_frame(input int done_k, input int renew, input bit drop_en);
    int w;
    bit chain;
    logic [DW-1:0] exp_byte;
    w = pick();
    apply_stimulus();
    step();
    do begin
      check_output("tx_start", tx_start, 1);
      check_output("gnt", gnt, 32'(1 << w));
      check_output("owner", owner, 32'(w));
      check_output("tx_data", tx_data, req_byte[w]);
      exp_byte = req_byte[w];
      step();
      if (renew > 0) begin
        req_byte[w] = 8'($urandom);
        renew--;
      end else begin
        pend[w] = 1'b0;
      end
      if (drop_en) arb_en = 1'b0;
      apply_stimulus();
      for (int c = 1; c <= TO; c++) begin
        check_output("busy_hold", busy, 1);
        check_output("tx_data_hold", tx_data, exp_byte);
        check_output("busy_no_pulse", {tx_start, gnt, timeout_err}, 0);
        if (c == done_k) tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        if (c == done_k) break;
      end
      chain = 1'b0;
`ifdef UART_TX_ARB_LOCK_EN
      chain = (done_k != 0) && req_lock[w] && pend[w] && arb_en;
`endif
      if (!chain) begin
        check_output("end_busy", busy, 0);
        check_output("end_timeout_err", timeout_err, 32'(done_k == 0));
        check_output("end_owner", owner, 32'(w));
        rr = (w + 1) % N;
      end
    end while (chain);
  endtask

  initial begin
    int dk;
    rst_n    = 1'b0;
    arb_en   = 1'b1;
    tx_done  = 1'b0;
    req      = '0;
    req_data = '0;
    pend     = '0;
    rr       = 0;
    for (int i = 0; i < N; i++) req_byte[i] = '0;
`ifdef UART_TX_ARB_LOCK_EN
    req_lock = '0;
`endif

    do_reset();

    // Single requester 2 with 8'hA5, then 4'b1001 from rr_ptr 3 wraps to 0.
    pend = 4'b0100;
    req_byte[2] = 8'hA5;
    run_frame(5, 0, 1'b0);
    pend = 4'b1001;
    req_byte[0] = 8'h3C;
    req_byte[3] = 8'hC3;
    run_frame(4, 0, 1'b0);
    run_frame(4, 0, 1'b0);

    // All four requesting with distinct bytes: order 0,1,2,3,0.
    do_reset();
    pend = 4'b1111;
    for (int i = 0; i < N; i++) req_byte[i] = 8'(8'h10 + i);
    for (int k = 0; k < 5; k++) run_frame(10, 1, 1'b0);

    // Watchdog expiry, then tx_done on the expiry cycle itself.
    pend = 4'b0010;
    req_byte[1] = 8'h77;
    run_frame(0, 0, 1'b0);
    pend = 4'b0001;
    req_byte[0] = 8'h88;
    run_frame(TO, 0, 1'b0);

    // arb_en dropped mid-frame: frame completes, no new grant until re-enabled.
    pend = 4'b0011;
    req_byte[0] = 8'h5A;
    req_byte[1] = 8'hA5;
    run_frame(6, 1, 1'b1);
    idle_cycles(4);
    arb_en = 1'b1;
    run_frame(6, 0, 1'b0);

    // Reset in the middle of BUSY: everything returns to zero without pulses.
    pend = 4'b0100;
    req_byte[2] = 8'hE7;
    apply_stimulus();
    step();
    check_output("pre_rst_tx_start", tx_start, 1);
    step();
    step();
    rst_n = 1'b0;
    step();
    check_output("mid_rst_busy", busy, 0);
    check_output("mid_rst_pulses", {tx_start, gnt, timeout_err}, 0);
    check_output("mid_rst_owner", owner, 0);
    check_output("mid_rst_tx_data", tx_data, 0);
    rst_n = 1'b1;
    pend = '0;
    apply_stimulus();
    rr = 0;
    idle_cycles(3);

`ifdef UART_TX_ARB_LOCK_EN
    // Locked burst of three bytes from requester 1, then lock released.
    do_reset();
    req_lock = 4'b0010;
    pend = 4'b0010;
    req_byte[1] = 8'h61;
    run_frame(10, 2, 1'b0);
    req_lock = '0;
    pend = 4'b0001;
    req_byte[0] = 8'h30;
    run_frame(10, 0, 1'b0);
`endif

    // Randomized frames: requesters join, drop out and re-request at random.
    for (int f = 0; f < 40; f++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && ($urandom_range(1, 0) == 1)) begin
          pend[i] = 1'b1;
          req_byte[i] = 8'($urandom);
        end else if (pend[i] && ($urandom_range(7, 0) == 0)) begin
          pend[i] = 1'b0;
        end
      end
      if (pend == '0) begin
        dk = $urandom_range(N - 1, 0);
        pend[dk] = 1'b1;
        req_byte[dk] = 8'($urandom);
      end
`ifdef UART_TX_ARB_LOCK_EN
      req_lock = 4'($urandom);
`endif
      case ($urandom_range(9, 0))
        0:       dk = 0;
        1:       dk = TO;
        default: dk = $urandom_range(12, 1);
      endcase
      run_frame(dk, $urandom_range(2, 0), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL sim_timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

endmodule
